return_addr_stack: RTL and testbench
====================================

// Module: return_addr_stack
// PURPOSE
//   Hardware return-address stack for the processor's CALL/RET flow. Sits directly upstream
//   of the PC source mux: on CALL it stores pc_plus1, and on RET it presents the saved address
//   as the fourth PC source in the same cycle. It replaces the bare stack with bounded depth,
//   full/empty status and sticky overflow/underflow flags.
// PARAMETERS
//   ADDR_WIDTH  12   width of a stored return address (matches PC width)
//   DEPTH       8    number of entries; must be a power of two and at least 2
//   PTR_WIDTH   3    $clog2(DEPTH); width of the internal write pointer
// PORTS
//   clk         in   1             rising-edge clock
//   rst         in   1             asynchronous reset, active-low (0 = reset)
//   push        in   1             CALL: store push_addr at the next rising edge
//   pop         in   1             RET: discard the top entry at the next rising edge
//   push_addr   in   ADDR_WIDTH    address to save (pc_plus1 from the datapath)
//   clr_flags   in   1             synchronous clear of overflow and underflow
//   top_addr    out  ADDR_WIDTH    current top entry; 0 when the stack is empty
//   count       out  PTR_WIDTH+1   number of valid entries, 0..DEPTH
//   empty       out  1             count == 0
//   full        out  1             count == DEPTH
//   overflow    out  1             sticky: a push was made while full
//   underflow   out  1             sticky: a pop was made while empty
// BEHAVIOUR
//   - Storage is mem[0..DEPTH-1], used as a circular buffer. wp indexes the next free slot,
//     modulo DEPTH.
//   - top_addr = (count==0) ? 0 : mem[(wp-1) mod DEPTH].
//     It is combinational from registers, so there is zero latency: the PC mux uses it
//     during the RET cycle itself.
//   - empty and full are combinational from count.
//   - All state updates happen on the rising edge of clk while rst=1. The cases are:
//     push only, not full: mem[wp] <= push_addr; wp <= wp+1; count <= count+1.
//     push only, full: mem[wp] <= push_addr, which overwrites the oldest entry;
//       wp <= wp+1; count stays DEPTH; overflow <= 1.
//     pop only, count > 0: wp <= wp-1; count <= count-1. mem is unchanged.
//     pop only, empty: no state change; underflow <= 1.
//     push and pop, count > 0: mem[wp-1] <= push_addr, replacing the top entry.
//       wp and count are unchanged. No flag is set, even when full.
//     push and pop, empty: underflow <= 1, then a normal push is performed (count becomes 1).
//     neither: hold.
//   - Pointer arithmetic wraps modulo DEPTH. count never exceeds DEPTH and never goes below 0.
//   - clr_flags=1 clears overflow and underflow at the edge. If a flag event occurs in the
//     same cycle, the set wins for that flag.
//   - Reset (rst=0, asynchronous) takes effect immediately, including between clock edges
//     in the middle of a push/pop sequence:
//     wp=0, count=0, overflow=0, underflow=0, all mem entries = 0.
//     Outputs therefore read top_addr=0, count=0, empty=1, full=0.
//     push and pop are ignored while rst=0.
//   - There is no internal state machine beyond the wp/count registers. Flags change only
//     at clock edges or on reset.
// TESTING
//   1. Assert rst=0, then release -> empty=1, full=0, count=0, top_addr=0x000, both flags 0.
//   2. Push 0x010, 0x020, 0x030 on consecutive cycles -> count=3, top_addr=0x030.
//      Pop once -> top_addr=0x020 after the edge; count=2.
//   3. Push 0x100..0x107 -> full=1, count=8. Then push 0x1FF -> overflow=1, count=8.
//      Eight pops return 0x1FF, 0x107, 0x106, ..., 0x101 in that order, then empty=1.
//   4. Pop while empty -> underflow=1, count=0, top_addr=0. Then clr_flags=1 for one cycle
//      -> underflow=0. clr_flags together with a pop on empty -> underflow stays 1.
//   5. With the stack holding 0x010 and 0x020, drive push=pop=1 with push_addr=0x0AB
//      -> count=2, top_addr=0x0AB; one pop -> top_addr=0x010.
//   6. Push 0x055 twice, then drop rst to 0 mid-cycle -> before the next edge, count=0,
//      top_addr=0, empty=1. After release, a pop sets underflow=1.

Source files
------------

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - bounded return-address stack with full/empty status and sticky overflow/underflow
module return_addr_stack #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic                  clr_flags,
    output logic [ADDR_WIDTH-1:0] top_addr,
    output logic [PTR_WIDTH:0]    count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wp;
    logic [PTR_WIDTH-1:0]  wp_prev;
    logic                  replace_top;
    logic                  do_push;
    logic                  do_pop;
    logic                  set_ovf;
    logic                  set_unf;

    assign wp_prev  = wp - PTR_WIDTH'(1);
    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign top_addr = empty ? '0 : mem[wp_prev];

    // A simultaneous push/pop on a non-empty stack swaps the top in place;
    // on an empty stack the pop underflows and the push proceeds normally.
    always_comb begin
        replace_top = push && pop && !empty;
        do_push     = push && !replace_top;
        do_pop      = pop && !push && !empty;
        set_ovf     = push && !pop && full;
        set_unf     = pop && empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (replace_top) begin
                mem[wp_prev] <= push_addr;
            end else if (do_push) begin
                mem[wp] <= push_addr;
                wp      <= wp + PTR_WIDTH'(1);
                if (!full) begin
                    count <= count + (PTR_WIDTH + 1)'(1);
                end
            end else if (do_pop) begin
                wp    <= wp_prev;
                count <= count - (PTR_WIDTH + 1)'(1);
            end
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (set_ovf) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (set_unf) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - scoreboard bench for return_addr_stack against a queue-based model
`timescale 1ns/1ps
module tb_return_addr_stack;

    localparam int AW    = 12;
    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] push_addr = '0;
    logic          clr_flags = 1'b0;
    logic [AW-1:0] top_addr;
    logic [PW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    return_addr_stack #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .PTR_WIDTH(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_addr (push_addr),
        .clr_flags (clr_flags),
        .top_addr  (top_addr),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] top;
        int            cnt;
        logic          emp;
        logic          ful;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] stack_q[$];   // oldest at front, top at back
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            done = 1'b0;

    function automatic exp_t snapshot();
        exp_t e;
        e.top = (stack_q.size() == 0) ? '0 : stack_q[stack_q.size() - 1];
        e.cnt = stack_q.size();
        e.emp = (stack_q.size() == 0);
        e.ful = (stack_q.size() == DEPTH);
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are presented after every clock edge and after any reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("top_addr",  int'(top_addr),  int'(e.top));
                check("count",     int'(count),     e.cnt);
                check("empty",     int'(empty),     int'(e.emp));
                check("full",      int'(full),      int'(e.ful));
                check("overflow",  int'(overflow),  int'(e.ovf));
                check("underflow", int'(underflow), int'(e.unf));
            end
        end
    end

    task automatic step(input logic p, input logic q, input logic [AW-1:0] a, input logic c);
        bit set_o, set_u;
        @(negedge clk);
        push = p; pop = q; push_addr = a; clr_flags = c;
        set_o = 1'b0; set_u = 1'b0;
        if (p && q) begin
            if (stack_q.size() > 0) begin
                stack_q[stack_q.size() - 1] = a;
            end else begin
                set_u = 1'b1;
                stack_q.push_back(a);
            end
        end else if (p) begin
            if (stack_q.size() == DEPTH) begin
                set_o = 1'b1;
                void'(stack_q.pop_front());
            end
            stack_q.push_back(a);
        end else if (q) begin
            if (stack_q.size() > 0) void'(stack_q.pop_back());
            else set_u = 1'b1;
        end
        if (set_o) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (set_u) m_unf = 1'b1; else if (c) m_unf = 1'b0;
        exp_q.push_back(snapshot());
    endtask

    // Asserts reset between edges, with no active command, then releases before the next edge.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        push = 1'b0; pop = 1'b0; clr_flags = 1'b0;
        stack_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
        exp_q.push_back(snapshot());
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        int guard;
        #2;
        exp_q.push_back(snapshot());
        rst = 1'b0;
        #6;
        rst = 1'b1;

        step(1, 0, 12'h010, 0);
        step(1, 0, 12'h020, 0);
        step(1, 0, 12'h030, 0);
        step(0, 1, 12'h000, 0);
        step(0, 1, 12'h000, 0);
        step(0, 1, 12'h000, 0);
        for (int i = 0; i < 8; i++) step(1, 0, AW'(12'h100 + i), 0);
        step(1, 0, 12'h1FF, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 12'h000, 0);
        step(0, 1, 12'h000, 0);
        step(0, 0, 12'h000, 1);
        step(0, 1, 12'h000, 1);
        step(0, 0, 12'h000, 1);
        step(1, 0, 12'h010, 0);
        step(1, 0, 12'h020, 0);
        step(1, 1, 12'h0AB, 0);
        step(0, 1, 12'h000, 0);
        step(0, 1, 12'h000, 0);
        step(1, 1, 12'h0CD, 0);
        step(1, 0, 12'h055, 0);
        step(1, 0, 12'h055, 0);
        mid_reset();
        step(0, 1, 12'h000, 0);

        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                mid_reset();
            end else begin
                step(r < 50, (r >= 40) && (r < 85), AW'($urandom), $urandom_range(0, 15) == 0);
            end
        end
        step(0, 0, 12'h000, 0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        if (!done) begin
            $display("FAIL watchdog: simulation time exceeded, expected completion");
            $fatal(1, "watchdog");
        end
    end

endmodule
